regfile_multiport: RTL and testbench

Parametrised multi-port integer register file for the pipelined datapath. It generalises the single-write/dual-read file with configurable width, depth, read-port count and write-port count, and adds a per-register busy scoreboard. Decode reads operands and reserves destinations; writeback ports clear reservations. It sits between the decode and writeback stages, and hazard logic consumes `busy`.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/regfile_mp_if.sv | 33 +++
 rtl/rf_scoreboard.sv | 46 ++++
 rtl/regfile_multiport.sv | 99 +++++++++
 tb/tb_regfile_multiport.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the integer register file and its neighbours.
package cpu_types_pkg;

  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // Register index sized for the default 32-entry file
  typedef logic [AW_DEF-1:0] regsel_t;

  localparam regsel_t REG_ZERO = '0;

  // One writeback port as seen by the register file
  typedef struct packed {
    logic        wen;
    regsel_t     wsel;
    logic [31:0] wdat;
  } rf_wport_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback and the multi-port register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  import cpu_types_pkg::*;

  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0][AW-1:0]     rsel;
  logic [NRD-1:0][DATA_W-1:0] rdat;
  logic [NWR-1:0]             wen;
  logic [NWR-1:0][AW-1:0]     wsel;
  logic [NWR-1:0][DATA_W-1:0] wdat;
  logic                       rsv_en;
  logic [AW-1:0]              rsv_sel;
  logic                       flush;
  logic [NREGS-1:0]           busy;
  logic                       wr_conflict;

  modport rf (
    input  rsel, wen, wsel, wdat, rsv_en, rsv_sel, flush,
    output rdat, busy, wr_conflict
  );

  modport tb (
    output rsel, wen, wsel, wdat, rsv_en, rsv_sel, flush,
    input  rdat, busy, wr_conflict
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: flush beats reserve, reserve beats write-clear.
// Register 0 never goes busy.
module rf_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NWR-1:0]         wen,
  input  logic [NWR-1:0][AW-1:0] wsel,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_sel,
  input  logic                   flush,
  output logic [NREGS-1:0]       busy
);

  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:1] busy_nxt;
  logic [NREGS-1:1] clr;

  // Next busy state per register in priority order
  always_comb begin
    clr      = '0;
    busy_nxt = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (wen[p] && wsel[p] == AW'(r)) clr[r] = 1'b1;
      end
      if (flush)                              busy_nxt[r] = 1'b0;
      else if (rsv_en && rsv_sel == AW'(r))   busy_nxt[r] = 1'b1;
      else if (clr[r])                        busy_nxt[r] = 1'b0;
    end
  end

  // Busy register, cleared asynchronously
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) busy_q <= '0;
    else       busy_q <= busy_nxt;
  end

  assign busy = {busy_q, 1'b0};

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port integer register file with busy scoreboard.
// Optional same-cycle write-through on reads: define REGFILE_BYPASS_EN.
module regfile_multiport
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  regfile_mp_if.rf   bus
);

  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0] mem    [1:NREGS-1];
  logic [DATA_W-1:0] wr_val [1:NREGS-1];
  logic [NREGS-1:1]  wr_hit;
  logic              conflict_now;
  logic              conflict_q;

  // Resolve per-register write; the highest-index port wins
  always_comb begin
    wr_hit = '0;
    for (int r = 1; r < NREGS; r++) begin
      wr_val[r] = '0;
      for (int p = 0; p < NWR; p++) begin
        if (bus.wen[p] && bus.wsel[p] == AW'(r)) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = bus.wdat[p];
        end
      end
    end
  end

  // Detect two ports writing the same non-zero register
  always_comb begin
    conflict_now = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      for (int q = p + 1; q < NWR; q++) begin
        if (bus.wen[p] && bus.wen[q] && bus.wsel[p] == bus.wsel[q] &&
            bus.wsel[p] != AW'(REG_ZERO))
          conflict_now = 1'b1;
      end
    end
  end

  // Data array update; register 0 has no storage
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 1; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) mem[r] <= wr_val[r];
      end
    end
  end

  // Sticky conflict flag, cleared only by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) conflict_q <= 1'b0;
    else       conflict_q <= conflict_q | conflict_now;
  end

  assign bus.wr_conflict = conflict_q;

  // Combinational read ports, forced to zero while in reset
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      bus.rdat[k] = '0;
      if (nRST && bus.rsel[k] != AW'(REG_ZERO)) begin
        bus.rdat[k] = mem[bus.rsel[k]];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NWR; p++) begin
          if (bus.wen[p] && bus.wsel[p] == bus.rsel[k]) bus.rdat[k] = bus.wdat[p];
        end
`endif
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .CLK     (CLK),
    .nRST    (nRST),
    .wen     (bus.wen),
    .wsel    (bus.wsel),
    .rsv_en  (bus.rsv_en),
    .rsv_sel (bus.rsv_sel),
    .flush   (bus.flush),
    .busy    (bus.busy)
  );

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: directed vectors plus a random stress phase,
// expected values queued by stimulus and checked by a negedge monitor.
module tb_regfile_multiport;
  import cpu_types_pkg::*;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int NRD    = 4;
  localparam int NWR    = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_RDAT = 0;
  localparam int K_BUSY = 1;
  localparam int K_CONF = 2;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sq[$];

  regfile_mp_if #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) u_if ();

  regfile_multiport #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (u_if.rf)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: compare every queued expectation due in this cycle
  always @(negedge CLK) begin
    exp_t        e;
    logic [31:0] act;
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      e = sq.pop_front();
      case (e.kind)
        K_RDAT:  act = u_if.rdat[e.idx];
        K_BUSY:  act = u_if.busy;
        default: act = {31'b0, u_if.wr_conflict};
      endcase
      checks++;
      if (e.cyc != cyc || act !== e.val) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, e.cyc, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(int kind, int idx, logic [31:0] val, string name, int off = 0);
    exp_t e;
    e.cyc = cyc + off; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    sq.push_back(e);
  endtask

  task automatic idle();
    u_if.wen = '0; u_if.rsv_en = 1'b0; u_if.flush = 1'b0;
  endtask

  task automatic drive_wr(int p, rf_wport_t w);
    u_if.wen[p] = w.wen; u_if.wsel[p] = w.wsel; u_if.wdat[p] = w.wdat;
  endtask

  task automatic reserve(regsel_t r);
    u_if.rsv_en = 1'b1; u_if.rsv_sel = r;
  endtask

  // Reference model state for the stress phase
  logic [31:0]      m_mem [NREGS];
  logic [NREGS-1:0] m_busy;
  logic             m_conf;

  function automatic logic [31:0] model_read(int k);
    logic [31:0] v;
    regsel_t s;
    s = u_if.rsel[k];
    v = (s == REG_ZERO) ? 32'h0 : m_mem[s];
    if (BYP && s != REG_ZERO)
      for (int p = 0; p < NWR; p++)
        if (u_if.wen[p] && u_if.wsel[p] == s) v = u_if.wdat[p];
    return v;
  endfunction

  task automatic model_update();
    logic [NREGS-1:0] nb;
    nb = m_busy;
    for (int r = 1; r < NREGS; r++) begin
      logic clr;
      clr = 1'b0;
      for (int p = 0; p < NWR; p++) if (u_if.wen[p] && u_if.wsel[p] == regsel_t'(r)) clr = 1'b1;
      if (u_if.flush) nb[r] = 1'b0;
      else if (u_if.rsv_en && u_if.rsv_sel == regsel_t'(r)) nb[r] = 1'b1;
      else if (clr) nb[r] = 1'b0;
    end
    for (int p = 0; p < NWR; p++)
      if (u_if.wen[p] && u_if.wsel[p] != REG_ZERO) m_mem[u_if.wsel[p]] = u_if.wdat[p];
    if (u_if.wen[0] && u_if.wen[1] && u_if.wsel[0] == u_if.wsel[1] && u_if.wsel[0] != REG_ZERO)
      m_conf = 1'b1;
    m_busy = nb;
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    u_if.rsel = '0; u_if.wsel = '0; u_if.wdat = '0; u_if.rsv_sel = '0;
    step(); step();
    nRST = 1'b1;

    // Out of reset
    u_if.rsel[0] = 5'd1; u_if.rsel[1] = 5'd2; u_if.rsel[2] = 5'd3; u_if.rsel[3] = 5'd31;
    push_exp(K_BUSY, 0, 32'h0, "rst_busy");
    push_exp(K_CONF, 0, 32'h0, "rst_conflict");
    push_exp(K_RDAT, 0, 32'h0, "rst_rdat0");
    push_exp(K_RDAT, 3, 32'h0, "rst_rdat3");
    step();

    // Write r5 via port 0, read on port 0
    drive_wr(0, '{wen: 1'b1, wsel: 5'd5, wdat: 32'hDEADBEEF});
    u_if.rsel[0] = 5'd5;
    push_exp(K_RDAT, 0, BYP ? 32'hDEADBEEF : 32'h0, "wr5_same_cycle");
    step(); idle();
    push_exp(K_RDAT, 0, 32'hDEADBEEF, "wr5_next_cycle");
    step();

    // Both ports write r7
    drive_wr(0, '{wen: 1'b1, wsel: 5'd7, wdat: 32'h11});
    drive_wr(1, '{wen: 1'b1, wsel: 5'd7, wdat: 32'h22});
    u_if.rsel[1] = 5'd7;
    push_exp(K_RDAT, 1, BYP ? 32'h22 : 32'h0, "conflict_same_cycle");
    push_exp(K_CONF, 0, 32'h0, "conflict_not_yet");
    step(); idle();
    push_exp(K_RDAT, 1, 32'h22, "conflict_high_port_wins");
    push_exp(K_CONF, 0, 32'h1, "conflict_set");
    // Clean dual write elsewhere; flag must stay set
    drive_wr(0, '{wen: 1'b1, wsel: 5'd8, wdat: 32'h8});
    drive_wr(1, '{wen: 1'b1, wsel: 5'd9, wdat: 32'h9});
    step(); idle();
    u_if.rsel[2] = 5'd8; u_if.rsel[3] = 5'd9;
    push_exp(K_CONF, 0, 32'h1, "conflict_sticky");
    push_exp(K_RDAT, 2, 32'h8, "dual_write_r8");
    push_exp(K_RDAT, 3, 32'h9, "dual_write_r9");
    step();

    // Writes and reservations on r0
    drive_wr(0, '{wen: 1'b1, wsel: REG_ZERO, wdat: 32'hFFFFFFFF});
    reserve(REG_ZERO);
    u_if.rsel[2] = REG_ZERO;
    push_exp(K_RDAT, 2, 32'h0, "r0_same_cycle");
    step(); idle();
    push_exp(K_RDAT, 2, 32'h0, "r0_read_zero");
    push_exp(K_BUSY, 0, 32'h0, "r0_not_busy");
    step();

    // Scoreboard: reserve, reserve+write, write alone
    reserve(5'd3);
    step(); idle();
    push_exp(K_BUSY, 0, 32'h0000_0008, "rsv_r3");
    drive_wr(0, '{wen: 1'b1, wsel: 5'd3, wdat: 32'h33});
    reserve(5'd3);
    step(); idle();
    u_if.rsel[3] = 5'd3;
    push_exp(K_BUSY, 0, 32'h0000_0008, "rsv_beats_write_clear");
    push_exp(K_RDAT, 3, 32'h33, "write_while_busy");
    drive_wr(1, '{wen: 1'b1, wsel: 5'd3, wdat: 32'h44});
    push_exp(K_RDAT, 3, BYP ? 32'h44 : 32'h33, "r3_bypass_port1");
    step(); idle();
    push_exp(K_BUSY, 0, 32'h0, "write_clears_busy");
    push_exp(K_RDAT, 3, 32'h44, "r3_port1_data");
    step();

    // Flush against a same-cycle reservation
    reserve(5'd2);
    step(); idle();
    reserve(5'd4);
    step(); idle();
    push_exp(K_BUSY, 0, 32'h0000_0014, "busy_r2_r4");
    u_if.flush = 1'b1;
    reserve(5'd9);
    step(); idle();
    push_exp(K_BUSY, 0, 32'h0, "flush_clears_all");
    step();

    // Asynchronous reset in the middle of a cycle
    reserve(5'd11);
    step(); idle();
    u_if.rsel[0] = 5'd5; u_if.rsel[1] = 5'd7; u_if.rsel[2] = 5'd3; u_if.rsel[3] = 5'd11;
    push_exp(K_BUSY, 0, 32'h0000_0800, "pre_rst_busy");
    push_exp(K_RDAT, 0, 32'hDEADBEEF, "pre_rst_r5");
    push_exp(K_RDAT, 1, 32'h22, "pre_rst_r7");
    step();
    drive_wr(0, '{wen: 1'b1, wsel: 5'd11, wdat: 32'hAB});
    reserve(5'd12);
    #1 nRST = 1'b0;
    push_exp(K_RDAT, 0, 32'h0, "in_rst_rdat0");
    push_exp(K_RDAT, 1, 32'h0, "in_rst_rdat1");
    push_exp(K_RDAT, 3, 32'h0, "in_rst_rdat3");
    push_exp(K_BUSY, 0, 32'h0, "in_rst_busy");
    push_exp(K_CONF, 0, 32'h0, "in_rst_conflict");
    step();
    nRST = 1'b1;
    idle();
    push_exp(K_RDAT, 0, 32'h0, "post_rst_r5");
    push_exp(K_RDAT, 2, 32'h0, "post_rst_r3");
    push_exp(K_RDAT, 3, 32'h0, "post_rst_r11");
    push_exp(K_BUSY, 0, 32'h0, "post_rst_busy");
    step();

    // Random multi-port stress against the reference model
    for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
    m_busy = '0;
    m_conf = 1'b0;
    for (int n = 0; n < 60; n++) begin
      for (int p = 0; p < NWR; p++) begin
        u_if.wen[p]  = ($urandom_range(0, 3) != 0);
        u_if.wsel[p] = regsel_t'($urandom_range(0, 7));
        u_if.wdat[p] = $urandom();
      end
      u_if.rsv_en  = $urandom_range(0, 1) == 1;
      u_if.rsv_sel = regsel_t'($urandom_range(0, 7));
      u_if.flush   = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NRD; k++) u_if.rsel[k] = regsel_t'($urandom_range(0, 7));
      for (int k = 0; k < NRD; k++) push_exp(K_RDAT, k, model_read(k), $sformatf("stress_rdat%0d", k));
      push_exp(K_BUSY, 0, m_busy, "stress_busy");
      push_exp(K_CONF, 0, {31'b0, m_conf}, "stress_conflict");
      model_update();
      step();
    end
    idle();
    push_exp(K_BUSY, 0, m_busy, "stress_final_busy");
    push_exp(K_CONF, 0, {31'b0, m_conf}, "stress_final_conflict");
    step(); step();

    if (sq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
